uart_loader: RTL and testbench

- Byte-level controller that sits downstream of the UART receiver. It parses a framed load packet and writes 16-bit words into instruction/data memory.
- It holds the CPU in reset for the duration of a load.
- It consumes the receiver's data / data_ready pair and drives a single memory write port.
- Used to download programs over the serial link without resynthesis.

---
 rtl/uart_loader_pkg.sv | 17 +
 rtl/uart_loader_rx_byte_strobe.sv | 37 +++
 rtl/uart_loader.sv | 132 +++++++++++++
 tb/tb_uart_loader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CSUM
  } state_e;
endpackage

// File: rtl/uart_loader_rx_byte_strobe.sv
// Turns the receiver's byte-valid level into a one-cycle strobe and counts
// idle clocks since the last byte; timeout holds until a byte or clear.
module rx_byte_strobe #(
  parameter int TIMEOUT_CLKS = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_ready,
  input  logic clear,
  output logic byte_stb,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);

  logic          rx_ready_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign byte_stb = rx_ready & ~rx_ready_q;
  assign timeout  = (cnt_q == CW'(TIMEOUT_CLKS));

  // Saturates at the limit so the flag stays up until the FSM reacts.
  always_comb begin
    cnt_d = cnt_q;
    if (byte_stb || clear) cnt_d = '0;
    else if (!timeout)     cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rx_ready_q <= rx_ready;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_loader.sv
// Parses framed load packets from the UART receiver and writes 16-bit words
// to memory, holding the CPU in reset while a packet is in flight.
module uart_loader
  import loader_pkg::*;
#(
  parameter int               ADDR_WIDTH   = 16,
  parameter int               DATA_WIDTH   = 16,
  parameter int               TIMEOUT_CLKS = 500000,
  parameter logic [BYTE_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);
  logic byte_stb, timeout;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   base_q, base_d, len_q, len_d, idx_q, idx_d;
  logic [BYTE_W-1:0]   lo_q, lo_d, csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [WORD_W-1:0]   len_new;

  rx_byte_strobe #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_stb (
    .clk      (clk),
    .rst      (rst),
    .rx_ready (rx_ready),
    .clear    (state_q == ST_IDLE),
    .byte_stb (byte_stb),
    .timeout  (timeout)
  );

  assign len_new = {rx_data, len_q[BYTE_W-1:0]};

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (byte_stb) begin
      if (state_q != ST_IDLE && state_q != ST_CSUM) csum_d = csum_q + rx_data;
      unique case (state_q)
        ST_IDLE: if (rx_data == SYNC_BYTE) begin
          state_d = ST_ADDR_LO;
          err_d   = 1'b0;
          csum_d  = '0;
          hold_d  = 1'b1;
        end
        ST_ADDR_LO: begin base_d[BYTE_W-1:0] = rx_data; state_d = ST_ADDR_HI; end
        ST_ADDR_HI: begin base_d[WORD_W-1:BYTE_W] = rx_data; state_d = ST_LEN_LO; end
        ST_LEN_LO:  begin len_d[BYTE_W-1:0] = rx_data; state_d = ST_LEN_HI; end
        ST_LEN_HI: begin
          len_d   = len_new;
          idx_d   = '0;
          state_d = (len_new == '0) ? ST_CSUM : ST_DATA_LO;
        end
        ST_DATA_LO: begin lo_d = rx_data; state_d = ST_DATA_HI; end
        ST_DATA_HI: begin
          data_d  = DATA_WIDTH'({rx_data, lo_q});
          addr_d  = ADDR_WIDTH'(base_q) + ADDR_WIDTH'(idx_q);
          we_d    = 1'b1;
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q + 16'd1 == len_q) ? ST_CSUM : ST_DATA_LO;
        end
        ST_CSUM: begin
          if (rx_data == csum_q) done_d = 1'b1;
          else                   err_d  = 1'b1;
          state_d = ST_IDLE;
          hold_d  = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      hold_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign mem_we   = we_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;
endmodule

// File: tb/tb_uart_loader.sv
// Directed packet vectors plus hand-written timeout and async-reset sequences.
module tb_uart_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [15:0] mem_addr, mem_data;
  logic        mem_we, cpu_hold, done, err;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [15:0] wq_a[$];
  logic [15:0] wq_d[$];

  uart_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CLKS(100), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Every high-sampled cycle is logged, so a stretched strobe shows up as an extra write.
  always @(negedge clk) begin
    if (mem_we) begin
      wq_a.push_back(mem_addr);
      wq_d.push_back(mem_data);
    end
    if (done) done_cnt++;
  end

  typedef struct {
    logic [0:11][7:0] b;
    int               n;
    int               hold;
    int               sync_pos;
    logic             err_pre;
    int               nw;
    logic [0:1][15:0] ea;
    logic [0:1][15:0] ed;
    int               ndone;
    logic             eerr;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [0:11][7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b[i], 1);
  endtask

  initial begin
    int wbase, dbase;
    logic [0:11][7:0] pkt;

    vecs[0] = '{b: '{8'h55, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00},
                n: 8, hold: 1, sync_pos: 2, err_pre: 1'b0, nw: 0,
                ea: '{16'h0, 16'h0}, ed: '{16'h0, 16'h0}, ndone: 1, eerr: 1'b0};
    vecs[1] = '{b: '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hD0, 8'h00, 8'h00},
                n: 10, hold: 1, sync_pos: 0, err_pre: 1'b0, nw: 2,
                ea: '{16'h0010, 16'h0011}, ed: '{16'h1234, 16'hABCD}, ndone: 1, eerr: 1'b0};
    vecs[2] = '{b: '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hD1, 8'h00, 8'h00},
                n: 10, hold: 1, sync_pos: 0, err_pre: 1'b0, nw: 2,
                ea: '{16'h0010, 16'h0011}, ed: '{16'h1234, 16'hABCD}, ndone: 0, eerr: 1'b1};
    vecs[3] = '{b: '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'h00, 8'h00},
                n: 10, hold: 20, sync_pos: 0, err_pre: 1'b1, nw: 2,
                ea: '{16'hFFFF, 16'h0000}, ed: '{16'h2211, 16'h4433}, ndone: 1, eerr: 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_data", {16'h0, mem_data}, 32'h0);
    chk("rst_flags", {28'h0, mem_we, cpu_hold, done, err}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      wbase = wq_a.size();
      dbase = done_cnt;
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i == vecs[v].sync_pos) begin
          chk($sformatf("v%0d_err_pre", v), {31'h0, err}, {31'h0, vecs[v].err_pre});
          chk($sformatf("v%0d_hold_pre", v), {31'h0, cpu_hold}, 32'h0);
        end
        send_byte(vecs[v].b[i], vecs[v].hold);
        if (i == vecs[v].sync_pos)
          chk($sformatf("v%0d_hold_sync", v), {31'h0, cpu_hold}, 32'h1);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_nwrites", v), wq_a.size() - wbase, vecs[v].nw);
      for (int k = 0; k < vecs[v].nw && wbase + k < wq_a.size(); k++) begin
        chk($sformatf("v%0d_addr%0d", v, k), {16'h0, wq_a[wbase+k]}, {16'h0, vecs[v].ea[k]});
        chk($sformatf("v%0d_data%0d", v, k), {16'h0, wq_d[wbase+k]}, {16'h0, vecs[v].ed[k]});
      end
      chk($sformatf("v%0d_done", v), done_cnt - dbase, vecs[v].ndone);
      chk($sformatf("v%0d_err", v), {31'h0, err}, {31'h0, vecs[v].eerr});
      chk($sformatf("v%0d_hold_end", v), {31'h0, cpu_hold}, 32'h0);
    end

    // Timeout: stall after ADDR_HI; 100 idle clocks abort the packet.
    wbase = wq_a.size();
    send_byte(8'hA5, 1);
    send_byte(8'h10, 1);
    send_byte(8'h00, 1);
    repeat (88) @(negedge clk);
    chk("to_err_before", {31'h0, err}, 32'h0);
    chk("to_hold_before", {31'h0, cpu_hold}, 32'h1);
    repeat (20) @(negedge clk);
    chk("to_err_after", {31'h0, err}, 32'h1);
    chk("to_hold_after", {31'h0, cpu_hold}, 32'h0);
    chk("to_nowrite", wq_a.size() - wbase, 0);
    wbase = wq_a.size();
    dbase = done_cnt;
    send_pkt(vecs[1].b, vecs[1].n);
    repeat (3) @(negedge clk);
    chk("to_recover_writes", wq_a.size() - wbase, 2);
    chk("to_recover_done", done_cnt - dbase, 1);
    chk("to_recover_err", {31'h0, err}, 32'h0);

    // Async reset while waiting for the DATA_HI byte.
    wbase = wq_a.size();
    pkt = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h00, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 6);
    chk("ar_hold_before", {31'h0, cpu_hold}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_flags", {28'h0, mem_we, cpu_hold, done, err}, 32'h0);
    chk("ar_addr", {16'h0, mem_addr}, 32'h0);
    chk("ar_data", {16'h0, mem_data}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("ar_nowrite", wq_a.size() - wbase, 0);
    dbase = done_cnt;
    pkt = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hCE, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 8);
    repeat (3) @(negedge clk);
    chk("ar_post_writes", wq_a.size() - wbase, 1);
    if (wq_a.size() > wbase) begin
      chk("ar_post_addr", {16'h0, wq_a[wbase]}, 32'h0020);
      chk("ar_post_data", {16'h0, wq_d[wbase]}, 32'hBEEF);
    end
    chk("ar_post_done", done_cnt - dbase, 1);
    chk("ar_post_err", {31'h0, err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
